demux1_8_seq: RTL and testbench
===============================

# demux1_8_seq

Registered 1-to-8 demultiplexer and serial collector: the write-side counterpart of the team's registered 8:1 bit selector. A single serial bit on `IN` is steered into one of eight holding-register bits, either by explicit `Sel` address or by an internal auto-incrementing pointer. In auto mode, completed frames are latched into `Frame` with a one-cycle `Valid` pulse. It sits between a serial source and any parallel consumer, including the 8:1 selector for loopback.

## Interface
- `LAST_SEL`, default 7: final pointer value in auto mode. Legal range 0..7; frame length is `LAST_SEL`+1 bits.
- `CLK`  in  1  rising-edge clock; the only clock.
- `RST`  in  1  synchronous, active-high reset.
- `ENA`  in  1  write enable, sampled on the rising edge of `CLK`.
- `Mode`  in  1  0 = addressed (by `Sel`); 1 = auto-increment. Sampled every edge.
- `Sel`  in  3  target bit in addressed mode; ignored when `Mode`=1.
- `IN`  in  1  serial data bit.
- `Output`  out  8  live holding register.
- `Frame`  out  8  last completed auto-mode frame; bits above `LAST_SEL` are 0.
- `Valid`  out  1  one-cycle pulse when `Frame` is updated.
- `Ptr`  out  3  current auto-mode pointer.

## Operation
- The state is the pointer (`Ptr`) and the mode phase:
  - IDLE when `Mode`=0.
  - COLLECT when `Mode`=1.
- Reset (`RST`=1 at an edge) has priority over everything, including `ENA`. It sets `Output`=0x00, `Frame`=0x00, `Valid`=0 and `Ptr`=0.
- Addressed mode (`Mode`=0):
  - `ENA`=1: `Output[Sel]` <= `IN`; the other seven bits hold.
  - `ENA`=0: all bits hold. There is no high-Z; outputs are always driven.
  - `Ptr` is forced to 0 every edge. `Valid` is 0. `Frame` holds.
- Auto mode (`Mode`=1) with `ENA`=1:
  - `Output[Ptr]` <= `IN`.
  - If `Ptr` < `LAST_SEL`: `Ptr` <= `Ptr`+1 and `Valid` <= 0.
  - If `Ptr` == `LAST_SEL`:
    - `Frame` <= `Output`, with bit `Ptr` replaced by the incoming `IN` and bits above `LAST_SEL` forced to 0.
    - `Valid` <= 1 and `Ptr` <= 0 (wrap).
- Auto mode with `ENA`=0: `Output`, `Ptr` and `Frame` hold; `Valid` <= 0. Gaps between enabled cycles are allowed mid-frame.
- Output bits above `LAST_SEL` are never written in auto mode and retain earlier values.
- Mode change 1→0 mid-frame:
  - The partial frame is discarded; no `Valid` is raised and `Frame` is unchanged.
  - `Ptr` returns to 0.
  - Bits already written into `Output` remain.
- Mode change 0→1: collection starts at `Ptr`=0 on the first enabled auto edge.
- When `Mode`=0, a concurrent `ENA` write uses `Sel`. The pointer clear and the write happen on the same edge.
- Reset mid-frame: the partial frame is lost and all outputs return to their reset values on that edge.

## Timing
- Writes are visible on `Output` one cycle after the sampling edge.
- `Frame` and `Valid` update on the same edge as the final (`Ptr`==`LAST_SEL`) write. `Valid` is high for exactly one cycle.
- Back-to-back frames with `ENA` held high:
  - `Valid` pulses once every `LAST_SEL`+1 cycles.
  - With `LAST_SEL`=0, `Valid` stays high continuously while `ENA`=1 and `Mode`=1, and `Frame[0]` follows `IN` with one cycle of latency.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: drive junk on all inputs, assert `RST` for one edge → `Output`=0x00, `Frame`=0x00, `Valid`=0, `Ptr`=0, even with `ENA`=1.
- Addressed mode: `Mode`=0, `ENA`=1, `Sel`=3 then `Sel`=6 with `IN`=1 → `Output`=0x08, then 0x48. Then `ENA`=0, `Sel`=0, `IN`=1 → `Output` stays 0x48. `Valid` stays 0 throughout.
- Auto frame: `LAST_SEL`=7, `Mode`=1, `ENA`=1 for 8 cycles with `IN`=1,0,1,1,0,0,1,0 → `Frame`=0x4D with `Valid` high for exactly one cycle, coincident with the 8th edge's update; `Ptr` wraps to 0.
- Gaps and back-to-back frames:
  - Repeat the auto-frame stimulus with `ENA` dropped for 3 cycles after the 4th bit → same `Frame`=0x4D, `Valid` delayed by 3 cycles.
  - Then send a second frame with all bits 1 → `Frame`=0xFF with one pulse.
- Abort: in auto mode, write 5 bits, then set `Mode`=0 for one cycle, then `Mode`=1 and send 8 bits of 0xA5 (LSB first) → no `Valid` for the partial frame, then `Frame`=0xA5 with one `Valid`.
- Edge parameters and mid-frame reset:
  - `LAST_SEL`=2: bits 1,1,0 → `Frame`=0x03 with `Valid`; `Output[7:3]` unchanged.
  - Assert `RST` after 2 bits of the next frame → all outputs cleared, no `Valid`.

Source files
------------

// File: rtl/demux1_8_seq_if.sv
// rtl/demux1_8_seq_if.sv - serial write port and parallel result bundle for demux1_8_seq
interface demux1_8_seq_if;
  logic       ENA;
  logic       Mode;
  logic [2:0] Sel;
  logic       IN;
  logic [7:0] Output;
  logic [7:0] Frame;
  logic       Valid;
  logic [2:0] Ptr;

  modport master (
    output ENA, Mode, Sel, IN,
    input  Output, Frame, Valid, Ptr
  );

  modport slave (
    input  ENA, Mode, Sel, IN,
    output Output, Frame, Valid, Ptr
  );
endinterface

// File: rtl/demux1_8_seq.sv
// rtl/demux1_8_seq.sv - registered 1:8 demultiplexer with auto-increment frame collector
module demux1_8_seq #(
  parameter int LAST_SEL = 7
) (
  input logic            CLK,
  input logic            RST,
  demux1_8_seq_if.slave  bus
);

  localparam logic [2:0] LAST       = 3'(LAST_SEL);
  localparam logic [7:0] FRAME_MASK = 8'((16'd1 << (LAST_SEL + 1)) - 16'd1);

  logic [7:0] out_q,   out_d;
  logic [7:0] frame_q, frame_d;
  logic       valid_q, valid_d;
  logic [2:0] ptr_q,   ptr_d;

  always_comb begin
    out_d   = out_q;
    frame_d = frame_q;
    valid_d = 1'b0;
    ptr_d   = ptr_q;
    if (!bus.Mode) begin
      // Leaving auto mode drops any partial frame by parking the pointer.
      ptr_d = 3'd0;
      if (bus.ENA) begin
        out_d[bus.Sel] = bus.IN;
      end
    end else if (bus.ENA) begin
      out_d[ptr_q] = bus.IN;
      if (ptr_q == LAST) begin
        // Snapshot includes the bit being written on this same edge.
        frame_d = out_d & FRAME_MASK;
        valid_d = 1'b1;
        ptr_d   = 3'd0;
      end else begin
        ptr_d = ptr_q + 3'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_q   <= 8'h00;
      frame_q <= 8'h00;
      valid_q <= 1'b0;
      ptr_q   <= 3'd0;
    end else begin
      out_q   <= out_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.Output = out_q;
  assign bus.Frame  = frame_q;
  assign bus.Valid  = valid_q;
  assign bus.Ptr    = ptr_q;

endmodule

// File: tb/tb_demux1_8_seq.sv
// tb/tb_demux1_8_seq.sv - directed vector bench for demux1_8_seq at LAST_SEL 7 and 2
module tb_demux1_8_seq;

  typedef struct {
    logic       rst;
    logic       ena;
    logic       mode;
    logic [2:0] sel;
    logic       din;
    logic [7:0] exp_out;
    logic [7:0] exp_frame;
    logic       exp_valid;
    logic [2:0] exp_ptr;
  } vec_t;

  logic CLK = 1'b0;
  logic rst_a, rst_b;
  int   checks = 0;
  int   errors = 0;

  demux1_8_seq_if a_if();
  demux1_8_seq_if b_if();

  demux1_8_seq #(.LAST_SEL(7)) dut_a (.CLK(CLK), .RST(rst_a), .bus(a_if.slave));
  demux1_8_seq #(.LAST_SEL(2)) dut_b (.CLK(CLK), .RST(rst_b), .bus(b_if.slave));

  always #5 CLK = ~CLK;

  function automatic vec_t mk(logic r, logic e, logic m, logic [2:0] s, logic d,
                              logic [7:0] o, logic [7:0] f, logic v, logic [2:0] p);
    vec_t t;
    t.rst = r; t.ena = e; t.mode = m; t.sel = s; t.din = d;
    t.exp_out = o; t.exp_frame = f; t.exp_valid = v; t.exp_ptr = p;
    return t;
  endfunction

  task automatic cmp(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %02h expected %02h", name, idx, act, exp);
    end
  endtask

  // Drive one vector at the falling edge, then check just after the rising edge.
  task automatic apply(input vec_t v, input bit use_b, input int idx);
    @(negedge CLK);
    if (use_b) begin
      rst_b = v.rst; b_if.ENA = v.ena; b_if.Mode = v.mode; b_if.Sel = v.sel; b_if.IN = v.din;
    end else begin
      rst_a = v.rst; a_if.ENA = v.ena; a_if.Mode = v.mode; a_if.Sel = v.sel; a_if.IN = v.din;
    end
    @(posedge CLK);
    #1;
    if (use_b) begin
      cmp("b_output", idx, b_if.Output, v.exp_out);
      cmp("b_frame",  idx, b_if.Frame,  v.exp_frame);
      cmp("b_valid",  idx, {7'd0, b_if.Valid}, {7'd0, v.exp_valid});
      cmp("b_ptr",    idx, {5'd0, b_if.Ptr},   {5'd0, v.exp_ptr});
    end else begin
      cmp("a_output", idx, a_if.Output, v.exp_out);
      cmp("a_frame",  idx, a_if.Frame,  v.exp_frame);
      cmp("a_valid",  idx, {7'd0, a_if.Valid}, {7'd0, v.exp_valid});
      cmp("a_ptr",    idx, {5'd0, a_if.Ptr},   {5'd0, v.exp_ptr});
    end
  endtask

  initial begin
    vec_t va[$];

    rst_a = 1'b1; a_if.ENA = 1'b1; a_if.Mode = 1'b1; a_if.Sel = 3'd5; a_if.IN = 1'b1;
    rst_b = 1'b1; b_if.ENA = 1'b0; b_if.Mode = 1'b0; b_if.Sel = 3'd0; b_if.IN = 1'b0;

    //                 rst  ena  mode sel   in    out    frame  v    ptr
    va.push_back(mk(1'b1,1'b1,1'b1,3'd5,1'b1, 8'h00,8'h00,1'b0,3'd0)); // reset wins over junk
    va.push_back(mk(1'b0,1'b1,1'b0,3'd3,1'b1, 8'h08,8'h00,1'b0,3'd0));
    va.push_back(mk(1'b0,1'b1,1'b0,3'd6,1'b1, 8'h48,8'h00,1'b0,3'd0));
    va.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b1, 8'h48,8'h00,1'b0,3'd0));
    // auto frame 1,0,1,1,0,0,1,0 -> 0x4D
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b1, 8'h49,8'h00,1'b0,3'd1));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd7,1'b0, 8'h49,8'h00,1'b0,3'd2));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b1, 8'h4D,8'h00,1'b0,3'd3));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b1, 8'h4D,8'h00,1'b0,3'd4));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b0, 8'h4D,8'h00,1'b0,3'd5));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b0, 8'h4D,8'h00,1'b0,3'd6));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b1, 8'h4D,8'h00,1'b0,3'd7));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b0, 8'h4D,8'h4D,1'b1,3'd0));
    va.push_back(mk(1'b0,1'b0,1'b1,3'd0,1'b1, 8'h4D,8'h4D,1'b0,3'd0));
    // same frame with a 3-cycle gap after the 4th bit
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b1, 8'h4D,8'h4D,1'b0,3'd1));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b0, 8'h4D,8'h4D,1'b0,3'd2));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b1, 8'h4D,8'h4D,1'b0,3'd3));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b1, 8'h4D,8'h4D,1'b0,3'd4));
    va.push_back(mk(1'b0,1'b0,1'b1,3'd0,1'b0, 8'h4D,8'h4D,1'b0,3'd4));
    va.push_back(mk(1'b0,1'b0,1'b1,3'd0,1'b1, 8'h4D,8'h4D,1'b0,3'd4));
    va.push_back(mk(1'b0,1'b0,1'b1,3'd0,1'b0, 8'h4D,8'h4D,1'b0,3'd4));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b0, 8'h4D,8'h4D,1'b0,3'd5));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b0, 8'h4D,8'h4D,1'b0,3'd6));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b1, 8'h4D,8'h4D,1'b0,3'd7));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b0, 8'h4D,8'h4D,1'b1,3'd0));
    // back-to-back all-ones frame
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b1, 8'h4D,8'h4D,1'b0,3'd1));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b1, 8'h4F,8'h4D,1'b0,3'd2));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b1, 8'h4F,8'h4D,1'b0,3'd3));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b1, 8'h4F,8'h4D,1'b0,3'd4));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b1, 8'h5F,8'h4D,1'b0,3'd5));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b1, 8'h7F,8'h4D,1'b0,3'd6));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b1, 8'h7F,8'h4D,1'b0,3'd7));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b1, 8'hFF,8'hFF,1'b1,3'd0));
    // abort after 5 zero bits; the addressed write clears bit 7 on the same edge
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b0, 8'hFE,8'hFF,1'b0,3'd1));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b0, 8'hFC,8'hFF,1'b0,3'd2));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b0, 8'hF8,8'hFF,1'b0,3'd3));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b0, 8'hF0,8'hFF,1'b0,3'd4));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b0, 8'hE0,8'hFF,1'b0,3'd5));
    va.push_back(mk(1'b0,1'b1,1'b0,3'd7,1'b0, 8'h60,8'hFF,1'b0,3'd0));
    // 0xA5 LSB first
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b1, 8'h61,8'hFF,1'b0,3'd1));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b0, 8'h61,8'hFF,1'b0,3'd2));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b1, 8'h65,8'hFF,1'b0,3'd3));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b0, 8'h65,8'hFF,1'b0,3'd4));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b0, 8'h65,8'hFF,1'b0,3'd5));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b1, 8'h65,8'hFF,1'b0,3'd6));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b0, 8'h25,8'hFF,1'b0,3'd7));
    va.push_back(mk(1'b0,1'b1,1'b1,3'd0,1'b1, 8'hA5,8'hA5,1'b1,3'd0));
    va.push_back(mk(1'b0,1'b0,1'b1,3'd0,1'b0, 8'hA5,8'hA5,1'b0,3'd0));

    for (int i = 0; i < va.size(); i++) begin
      apply(va[i], 1'b0, i);
    end

    // LAST_SEL=2: preload high bits, collect a 3-bit frame, then reset mid-frame
    apply(mk(1'b1,1'b1,1'b1,3'd0,1'b1, 8'h00,8'h00,1'b0,3'd0), 1'b1, 100);
    apply(mk(1'b0,1'b1,1'b0,3'd7,1'b1, 8'h80,8'h00,1'b0,3'd0), 1'b1, 101);
    apply(mk(1'b0,1'b1,1'b0,3'd4,1'b1, 8'h90,8'h00,1'b0,3'd0), 1'b1, 102);
    apply(mk(1'b0,1'b1,1'b1,3'd0,1'b1, 8'h91,8'h00,1'b0,3'd1), 1'b1, 103);
    apply(mk(1'b0,1'b1,1'b1,3'd0,1'b1, 8'h93,8'h00,1'b0,3'd2), 1'b1, 104);
    apply(mk(1'b0,1'b1,1'b1,3'd0,1'b0, 8'h93,8'h03,1'b1,3'd0), 1'b1, 105);
    apply(mk(1'b0,1'b1,1'b1,3'd0,1'b0, 8'h92,8'h03,1'b0,3'd1), 1'b1, 106);
    apply(mk(1'b0,1'b1,1'b1,3'd0,1'b1, 8'h92,8'h03,1'b0,3'd2), 1'b1, 107);
    apply(mk(1'b1,1'b1,1'b1,3'd0,1'b1, 8'h00,8'h00,1'b0,3'd0), 1'b1, 108);
    apply(mk(1'b0,1'b0,1'b1,3'd0,1'b0, 8'h00,8'h00,1'b0,3'd0), 1'b1, 109);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
